mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified memory between the fetch requester (IF, read-only) and the
//  data requester (MEM stage, load/store). Grants one requester per cycle and drives the
//  memory port. Registers read data back to the winner one cycle later. Guarantees fetch
//  forward progress with a starvation limit. Sits between the pipeline front/back ends and memory.
// PARAMETERS
//  ISIZE         32  address width
//  DSIZE         32  data width
//  STARVE_LIMIT  4   consecutive lost fetch cycles before fetch is forced to win (>=1)
//  CNT_W         16  width of the conflict performance counter
// PORTS
//  clk           in   1      clock, all state updates on posedge
//  rst           in   1      synchronous, active-high reset
//  if_req        in   1      fetch request; held high with stable if_addr until if_gnt
//  if_addr       in   ISIZE  fetch address
//  if_gnt        out  1      fetch owns memory port this cycle (combinational)
//  if_rvalid     out  1      if_rdata valid; one cycle after if_gnt
//  if_rdata      out  DSIZE  registered fetch read data
//  dm_req        in   1      data request; held with stable dm_we/addr/wdata until dm_gnt
//  dm_we         in   1      1=store, 0=load
//  dm_addr       in   ISIZE  data address
//  dm_wdata      in   DSIZE  store data
//  dm_gnt        out  1      data requester owns memory port this cycle (combinational)
//  dm_rvalid     out  1      dm_rdata valid; one cycle after a load grant (never after a store)
//  dm_rdata      out  DSIZE  registered load data
//  mem_wen       out  1      memory write enable
//  mem_addr      out  ISIZE  memory address
//  mem_data_in   out  DSIZE  memory write data
//  mem_data_out  in   DSIZE  memory read data, combinational from mem_addr
//  conflict_cnt  out  CNT_W  cycles with both requests high; saturates at all-ones
// BEHAVIOUR
//  Reset: rst=1 -> if_gnt=dm_gnt=mem_wen=0 combinationally; next edge clears if_rvalid,
//   dm_rvalid, if_rdata, dm_rdata, starve_cnt, conflict_cnt, state=IDLE. Responses pending
//   at reset are dropped. mem_addr=0, mem_data_in=0 while rst high.
//  State reg (owner of previous cycle): IDLE, FETCH, DATA.
//   next = FETCH if if_gnt; DATA if dm_gnt; else IDLE.
//  Arbitration (rst=0), exactly one or zero grants per cycle:
//   only if_req -> if_gnt. only dm_req -> dm_gnt. neither -> no grant, state->IDLE.
//   both -> dm_gnt, unless starve_cnt==STARVE_LIMIT -> if_gnt.
//  starve_cnt: +1 when if_req & ~if_gnt; cleared when if_gnt or ~if_req; never exceeds
//   STARVE_LIMIT. So after STARVE_LIMIT data wins, fetch wins the next contended cycle.
//  Port mux: if_gnt -> mem_addr=if_addr, mem_wen=0. dm_gnt -> mem_addr=dm_addr,
//   mem_data_in=dm_wdata, mem_wen=dm_we. No grant -> mem_addr=0, mem_wen=0, mem_data_in=0.
//  Response latency 1: at edge ending a grant cycle, winner's rdata <= mem_data_out and
//   rvalid<=1 (dm_rvalid only if dm_we=0); rvalid is a one-cycle pulse; rdata holds value
//   until next capture. Back-to-back grants to one requester give back-to-back rvalids.
//  Store then load to same address in consecutive dm grants: load returns stored data.
//  Requester dropping req before gnt: legal, request withdrawn, no response.
//  conflict_cnt: +1 on every cycle with if_req & dm_req (rst=0); holds at 2^CNT_W-1.
//  No combinational path from mem_data_out to any output except through rdata registers.
// TESTING
//  T1 reset: rst=1 with both reqs high 3 cycles -> no gnt, mem_wen=0, rvalids=0, cnt=0.
//  T2 lone fetch: if_req, if_addr=1, mem[1]=05031000 -> if_gnt same cycle, next cycle
//     if_rvalid=1, if_rdata=32'h05031000.
//  T3 store/load: dm store addr=9 data=DEADBEEF, then load addr=9 -> mem_wen=1 only in store
//     cycle, no dm_rvalid after store, dm_rvalid with DEADBEEF after load.
//  T4 contention, STARVE_LIMIT=4: both reqs held 10 cycles -> grants D,D,D,D,F,D,D,D,D,F;
//     conflict_cnt=10.
//  T5 reset mid-op: assert rst in cycle after a load grant -> dm_rvalid stays 0, state IDLE,
//     starve_cnt=0; first contended cycle after release goes to data.
//  T6 saturation, CNT_W=4: 20 contended cycles -> conflict_cnt stops at 15.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-port and status signals around the unified memory arbiter.
// master = pipeline requesters plus memory model; slave = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int ISIZE = 32,
    parameter int DSIZE = 32,
    parameter int CNT_W = 16
);
    logic             if_req;
    logic [ISIZE-1:0] if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [DSIZE-1:0] if_rdata;

    logic             dm_req;
    logic             dm_we;
    logic [ISIZE-1:0] dm_addr;
    logic [DSIZE-1:0] dm_wdata;
    logic             dm_gnt;
    logic             dm_rvalid;
    logic [DSIZE-1:0] dm_rdata;

    logic             mem_wen;
    logic [ISIZE-1:0] mem_addr;
    logic [DSIZE-1:0] mem_data_in;
    logic [DSIZE-1:0] mem_data_out;

    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_wen, mem_addr, mem_data_in, conflict_cnt
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_wen, mem_addr, mem_data_in, conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data stage: data wins
// contention until fetch has lost STARVE_LIMIT cycles in a row; read data returns one cycle later.
module mem_port_arbiter #(
    parameter int ISIZE        = 32,
    parameter int DSIZE        = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t           state_reg, state_next;
    logic [SW-1:0]    starve_reg, starve_next;
    logic [CNT_W-1:0] conflict_reg;
    logic             dm_rvalid_reg;
    logic [DSIZE-1:0] if_rdata_reg, dm_rdata_reg;

    logic             if_gnt, dm_gnt, contended;
    logic             mem_wen;
    logic [ISIZE-1:0] mem_addr;
    logic [DSIZE-1:0] mem_data_in;

    assign contended = bus.if_req & bus.dm_req;

    always_comb begin
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        state_next  = IDLE;
        starve_next = starve_reg;
        if (!rst) begin
            // Data normally wins contention; fetch is forced through once it has starved long enough.
            if (contended) begin
                if (starve_reg == STARVE_MAX) if_gnt = 1'b1;
                else                          dm_gnt = 1'b1;
            end else if (bus.if_req) begin
                if_gnt = 1'b1;
            end else if (bus.dm_req) begin
                dm_gnt = 1'b1;
            end

            if (if_gnt) begin
                mem_addr   = bus.if_addr;
                state_next = FETCH;
            end else if (dm_gnt) begin
                mem_addr    = bus.dm_addr;
                mem_data_in = bus.dm_wdata;
                mem_wen     = bus.dm_we;
                state_next  = DATA;
            end

            if (bus.if_req && !if_gnt && starve_reg != STARVE_MAX)
                starve_next = starve_reg + 1'b1;
            else if (!bus.if_req || if_gnt)
                starve_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            starve_reg    <= '0;
            conflict_reg  <= '0;
            dm_rvalid_reg <= 1'b0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            starve_reg    <= starve_next;
            dm_rvalid_reg <= dm_gnt & ~bus.dm_we;
            if (if_gnt)
                if_rdata_reg <= bus.mem_data_out;
            if (dm_gnt && !bus.dm_we)
                dm_rdata_reg <= bus.mem_data_out;
            if (contended && conflict_reg != CNT_MAX)
                conflict_reg <= conflict_reg + 1'b1;
        end
    end

    // A fetch owner last cycle is exactly the condition for a fetch response now.
    assign bus.if_rvalid    = (state_reg == FETCH);
    assign bus.dm_rvalid    = dm_rvalid_reg;
    assign bus.if_rdata     = if_rdata_reg;
    assign bus.dm_rdata     = dm_rdata_reg;
    assign bus.if_gnt       = if_gnt;
    assign bus.dm_gnt       = dm_gnt;
    assign bus.mem_wen      = mem_wen;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_data_in  = mem_data_in;
    assign bus.conflict_cnt = conflict_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 16-word combinational memory model;
// STARVE_LIMIT=4 and a 4-bit conflict counter so saturation is reachable quickly.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    logic [31:0] mem [16];

    mem_port_arbiter_if #(.ISIZE(32), .DSIZE(32), .CNT_W(4)) bus ();

    mem_port_arbiter #(.ISIZE(32), .DSIZE(32), .STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.mem_data_out = mem[bus.mem_addr[3:0]];
    always @(posedge clk) if (bus.mem_wen) mem[bus.mem_addr[3:0]] <= bus.mem_data_in;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    endtask

    task automatic reset_pulse();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'd3;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'd5; bus.dm_wdata = 32'h1234_5678;
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (bus.if_gnt !== 1'b0) $display("FAIL reset_if_gnt c%0d: got %b want 0", c, bus.if_gnt); else passed++;
            total++; if (bus.dm_gnt !== 1'b0) $display("FAIL reset_dm_gnt c%0d: got %b want 0", c, bus.dm_gnt); else passed++;
            total++; if (bus.mem_wen !== 1'b0) $display("FAIL reset_mem_wen c%0d: got %b want 0", c, bus.mem_wen); else passed++;
            total++; if (bus.mem_addr !== 32'd0) $display("FAIL reset_mem_addr c%0d: got %h want 0", c, bus.mem_addr); else passed++;
            total++; if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0) $display("FAIL reset_rvalid c%0d: got %b%b want 00", c, bus.if_rvalid, bus.dm_rvalid); else passed++;
            total++; if (bus.conflict_cnt !== 4'd0) $display("FAIL reset_cnt c%0d: got %0d want 0", c, bus.conflict_cnt); else passed++;
        end
        clear_inputs();
        rst = 1'b0;
        tick();
        $display("txn reset: 3 cycles with both requests under reset");
    endtask

    task automatic test_lone_fetch();
        bus.if_req = 1'b1; bus.if_addr = 32'd1;
        #1;
        total++; if (bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0) $display("FAIL fetch_gnt: got if=%b dm=%b want if=1 dm=0", bus.if_gnt, bus.dm_gnt); else passed++;
        total++; if (bus.mem_addr !== 32'd1 || bus.mem_wen !== 1'b0) $display("FAIL fetch_port: got addr=%h wen=%b want 1/0", bus.mem_addr, bus.mem_wen); else passed++;
        tick();
        bus.if_req = 1'b0;
        total++; if (bus.if_rvalid !== 1'b1) $display("FAIL fetch_rvalid: got %b want 1", bus.if_rvalid); else passed++;
        total++; if (bus.if_rdata !== 32'h0503_1000) $display("FAIL fetch_rdata: got %h want 05031000", bus.if_rdata); else passed++;
        total++; if (bus.dm_rvalid !== 1'b0) $display("FAIL fetch_no_dm_rvalid: got %b want 0", bus.dm_rvalid); else passed++;
        tick();
        total++; if (bus.if_rvalid !== 1'b0) $display("FAIL fetch_rvalid_pulse: got %b want 0", bus.if_rvalid); else passed++;
        $display("txn fetch addr=1 rdata=%h", bus.if_rdata);
    endtask

    task automatic test_store_load();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'd9; bus.dm_wdata = 32'hDEAD_BEEF;
        #1;
        total++; if (bus.dm_gnt !== 1'b1 || bus.mem_wen !== 1'b1) $display("FAIL store_gnt: got gnt=%b wen=%b want 1/1", bus.dm_gnt, bus.mem_wen); else passed++;
        total++; if (bus.mem_addr !== 32'd9 || bus.mem_data_in !== 32'hDEAD_BEEF) $display("FAIL store_port: got %h/%h want 9/deadbeef", bus.mem_addr, bus.mem_data_in); else passed++;
        tick();
        bus.dm_we = 1'b0; bus.dm_wdata = 32'h0;
        total++; if (bus.dm_rvalid !== 1'b0) $display("FAIL store_no_rvalid: got %b want 0", bus.dm_rvalid); else passed++;
        #1;
        total++; if (bus.dm_gnt !== 1'b1 || bus.mem_wen !== 1'b0) $display("FAIL load_gnt: got gnt=%b wen=%b want 1/0", bus.dm_gnt, bus.mem_wen); else passed++;
        tick();
        bus.dm_req = 1'b0;
        total++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hDEAD_BEEF) $display("FAIL load_data: got v=%b d=%h want 1/deadbeef", bus.dm_rvalid, bus.dm_rdata); else passed++;
        tick();
        total++; if (bus.dm_rvalid !== 1'b0 || bus.dm_rdata !== 32'hDEAD_BEEF) $display("FAIL load_hold: got v=%b d=%h want 0/deadbeef", bus.dm_rvalid, bus.dm_rdata); else passed++;
        $display("txn store addr=9 data=deadbeef, load addr=9 data=%h", bus.dm_rdata);
    endtask

    task automatic test_contention();
        bit exp_f [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        reset_pulse();
        bus.if_req = 1'b1; bus.if_addr = 32'd1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'd9;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++; if (bus.if_gnt !== exp_f[i] || bus.dm_gnt !== !exp_f[i]) $display("FAIL contend_gnt c%0d: got if=%b dm=%b want if=%b", i, bus.if_gnt, bus.dm_gnt, exp_f[i]); else passed++;
            total++; if (bus.mem_addr !== (exp_f[i] ? 32'd1 : 32'd9)) $display("FAIL contend_addr c%0d: got %h want %h", i, bus.mem_addr, exp_f[i] ? 32'd1 : 32'd9); else passed++;
            tick();
            total++; if (bus.if_rvalid !== exp_f[i] || bus.dm_rvalid !== !exp_f[i]) $display("FAIL contend_rvalid c%0d: got if=%b dm=%b want if=%b", i, bus.if_rvalid, bus.dm_rvalid, exp_f[i]); else passed++;
            $display("txn contend cycle %0d winner=%s", i, exp_f[i] ? "F" : "D");
        end
        clear_inputs();
        total++; if (bus.conflict_cnt !== 4'd10) $display("FAIL contend_cnt: got %0d want 10", bus.conflict_cnt); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_op();
        bit exp_f [5] = '{0, 0, 0, 0, 1};
        bus.if_req = 1'b1; bus.if_addr = 32'd1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'd9;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        total++; if (bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b0) $display("FAIL midrst_gnt: got if=%b dm=%b want 0/0", bus.if_gnt, bus.dm_gnt); else passed++;
        tick();
        rst = 1'b0;
        total++; if (bus.dm_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) $display("FAIL midrst_rvalid: got if=%b dm=%b want 0/0", bus.if_rvalid, bus.dm_rvalid); else passed++;
        total++; if (bus.dm_rdata !== 32'd0 || bus.conflict_cnt !== 4'd0) $display("FAIL midrst_clear: got rdata=%h cnt=%0d want 0/0", bus.dm_rdata, bus.conflict_cnt); else passed++;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (bus.if_gnt !== exp_f[i] || bus.dm_gnt !== !exp_f[i]) $display("FAIL midrst_arb c%0d: got if=%b dm=%b want if=%b", i, bus.if_gnt, bus.dm_gnt, exp_f[i]); else passed++;
            tick();
        end
        clear_inputs();
        tick();
        $display("txn reset mid-operation, arbitration restarted from data");
    endtask

    task automatic test_withdraw();
        bus.if_req = 1'b1; bus.if_addr = 32'd1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'd9;
        tick();
        clear_inputs();
        total++; if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b1) $display("FAIL withdraw_rvalid: got if=%b dm=%b want 0/1", bus.if_rvalid, bus.dm_rvalid); else passed++;
        #1;
        total++; if (bus.if_gnt !== 1'b0) $display("FAIL withdraw_gnt: got %b want 0", bus.if_gnt); else passed++;
        tick();
        total++; if (bus.if_rvalid !== 1'b0) $display("FAIL withdraw_no_resp: got %b want 0", bus.if_rvalid); else passed++;
        $display("txn fetch withdrawn after losing to load");
    endtask

    task automatic test_saturation();
        int exp_cnt;
        reset_pulse();
        bus.if_req = 1'b1; bus.if_addr = 32'd2;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'd3;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cnt = (i + 1 > 15) ? 15 : i + 1;
            total++; if (bus.conflict_cnt !== 4'(exp_cnt)) $display("FAIL sat_cnt c%0d: got %0d want %0d", i, bus.conflict_cnt, exp_cnt); else passed++;
        end
        clear_inputs();
        tick();
        total++; if (bus.conflict_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", bus.conflict_cnt); else passed++;
        $display("txn 20 contended cycles, conflict_cnt=%0d", bus.conflict_cnt);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 32'h1000_0000 + 32'(a);
        mem[1] = 32'h0503_1000;
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_contention();
        test_reset_mid_op();
        test_withdraw();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
